// File: rtl/axi_sram_slave.sv
// AXI4 slave over a 64-bit-word on-chip SRAM.
// Independent write and read FSMs; FIXED/INCR bursts, strobes, SLVERR.
module axi_sram_slave #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          ID_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic [63:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            wvalid,
  output logic            wready,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  input  logic            arvalid,
  output logic            arready,
  input  logic [ID_W-1:0] arid,
  input  logic [63:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            rvalid,
  input  logic            rready,
  output logic [ID_W-1:0] rid,
  output logic [63:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  logic [63:0] r_mem [DEPTH];

  wstate_e         r_wstate, w_wstate_nxt;
  logic            r_awready, r_wready, r_bvalid;
  logic [ID_W-1:0] r_awid, r_bid;
  logic [63:0]     r_waddr;
  logic [7:0]      r_awlen, r_wcnt;
  logic [1:0]      r_awburst, r_bresp;
  logic [2:0]      r_awsize;
  logic            r_werr;

  rstate_e         r_rstate, w_rstate_nxt;
  logic            r_arready, r_rvalid, r_rlast;
  logic [ID_W-1:0] r_rid;
  logic [63:0]     r_raddr, r_rdata;
  logic [7:0]      r_arlen, r_rcnt;
  logic [1:0]      r_arburst, r_rresp;
  logic [2:0]      r_arsize;

  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [63:0] w_widx, w_ridx, w_rnext, w_rld_addr;
  logic        w_wok, w_rok, w_wbeat_err, w_wlast_beat, w_werr_nxt;
  logic [1:0]  w_rld_burst;
  logic [2:0]  w_rld_size;
  logic        w_rld_err;

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;
  assign w_b_hs  = r_bvalid & bready;
  assign w_ar_hs = arvalid & r_arready;
  assign w_r_hs  = r_rvalid & rready;

  // Index stays 64-bit so a wrapped or huge offset is caught by the range test.
  assign w_widx = (r_waddr - BASE_ADDR) >> 3;
  assign w_wok  = (r_waddr >= BASE_ADDR)
               && ((w_widx >> DEPTH_LOG2) == 64'd0);
  assign w_wbeat_err  = !w_wok || r_awburst[1] || (r_awsize != 3'b011);
  assign w_wlast_beat = (r_wcnt == r_awlen);
  assign w_werr_nxt   = r_werr | w_wbeat_err | (wlast != w_wlast_beat);

  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE: if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA: if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP: if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awburst <= '0;
      r_awsize  <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_awid    <= awid;
        r_waddr   <= awaddr;
        r_awlen   <= awlen;
        r_awburst <= awburst;
        r_awsize  <= awsize;
        r_wcnt    <= '0;
        r_werr    <= 1'b0;
      end
      if (w_w_hs) begin
        r_wcnt <= r_wcnt + 8'd1;
        r_werr <= w_werr_nxt;
        if (r_awburst == 2'b01) r_waddr <= r_waddr + 64'd8;
        if (w_wlast_beat) begin
          r_bid   <= r_awid;
          r_bresp <= w_werr_nxt ? 2'b10 : 2'b00;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_w_hs && !w_wbeat_err) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i])
          r_mem[w_widx[DEPTH_LOG2-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign w_rnext     = (r_arburst == 2'b01) ? r_raddr + 64'd8 : r_raddr;
  assign w_rld_addr  = (r_rstate == R_IDLE) ? araddr  : w_rnext;
  assign w_rld_burst = (r_rstate == R_IDLE) ? arburst : r_arburst;
  assign w_rld_size  = (r_rstate == R_IDLE) ? arsize  : r_arsize;
  assign w_ridx      = (w_rld_addr - BASE_ADDR) >> 3;
  assign w_rok       = (w_rld_addr >= BASE_ADDR)
                    && ((w_ridx >> DEPTH_LOG2) == 64'd0);
  assign w_rld_err   = !w_rok || w_rld_burst[1] || (w_rld_size != 3'b011);

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Nonblocking SRAM read: a same-edge write is not visible to this load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arburst <= '0;
      r_arsize  <= '0;
      r_rcnt    <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs || (w_r_hs && !r_rlast)) begin
        r_raddr <= w_rld_addr;
        r_rdata <= w_rld_err ? 64'd0 : r_mem[w_ridx[DEPTH_LOG2-1:0]];
        r_rresp <= w_rld_err ? 2'b10 : 2'b00;
      end
      if (w_ar_hs) begin
        r_rid     <= arid;
        r_arlen   <= arlen;
        r_arburst <= arburst;
        r_arsize  <= arsize;
        r_rcnt    <= '0;
        r_rlast   <= (arlen == 8'd0);
      end else if (w_r_hs && !r_rlast) begin
        r_rcnt  <= r_rcnt + 8'd1;
        r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
      end
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave.
// Inputs driven and outputs sampled on the falling edge.
module tb_axi_sram_slave;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [1:0]  FIX  = 2'b00;
  localparam logic [1:0]  INC  = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [63:0] a,
                         input logic [7:0] len, input logic [1:0] bu);
    awid = id; awaddr = a; awlen = len; awburst = bu;
    awsize = 3'b011; awvalid = 1'b1;
    for (int i = 0; i < 20 && !awready; i++) @(negedge clk);
    chk("awready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 20 && !wready; i++) @(negedge clk);
    chk("wready", wready, 1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_chk(input logic [3:0] id, input logic [1:0] rs);
    bready = 1'b1;
    for (int i = 0; i < 20 && !bvalid; i++) @(negedge clk);
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, rs);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [63:0] a,
                         input logic [7:0] len, input logic [1:0] bu);
    arid = id; araddr = a; arlen = len; arburst = bu;
    arsize = 3'b011; arvalid = 1'b1;
    for (int i = 0; i < 20 && !arready; i++) @(negedge clk);
    chk("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic r_chk(input logic [3:0] id, input logic [63:0] d,
                       input logic [1:0] rs, input logic l);
    for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
    chk("rvalid", rvalid, 1);
    chk("rid", rid, id);
    chk("rdata", rdata, d);
    chk("rresp", rresp, rs);
    chk("rlast", rlast, l);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr1(input logic [3:0] id, input logic [63:0] a,
                     input logic [63:0] d, input logic [7:0] s,
                     input logic [1:0] rs);
    aw_send(id, a, 8'd0, INC);
    w_send(d, s, 1'b1);
    b_chk(id, rs);
  endtask

  logic [63:0] d3 [4];
  logic [63:0] e8 [8];
  logic        pat [6];
  int          bi;

  initial begin
    rst_n = 1'b0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
    awsize = 3'b011; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0;
    arsize = 3'b011; arburst = 0; rready = 0;
    for (int i = 0; i < 4; i++) d3[i] = 64'h0101_0101_0101_0101 * (i + 1);
    for (int i = 0; i < 8; i++) e8[i] = 64'hE0E0_0000_0000_0000 + i;
    pat[0] = 1; pat[1] = 0; pat[2] = 1;
    pat[3] = 1; pat[4] = 0; pat[5] = 1;

    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rlast", rlast, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);

    // T1 single beat
    wr1(4'd3, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 2'b00);
    ar_send(4'd5, BASE + 64'h10, 8'd0, INC);
    r_chk(4'd5, 64'h1122_3344_5566_7788, 2'b00, 1'b1);

    // T2 strobes
    wr1(4'd3, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00);
    ar_send(4'd1, BASE + 64'h10, 8'd0, INC);
    r_chk(4'd1, 64'h1122_3344_FFFF_FFFF, 2'b00, 1'b1);

    // T3 INCR len3 with stalled reader
    aw_send(4'd1, BASE, 8'd3, INC);
    for (int b = 0; b < 4; b++) w_send(d3[b], 8'hFF, b == 3);
    b_chk(4'd1, 2'b00);
    ar_send(4'd2, BASE, 8'd3, INC);
    bi = 0;
    for (int c = 0; c < 6; c++) begin
      chk("t3_rvalid", rvalid, 1);
      chk("t3_rdata", rdata, d3[bi]);
      chk("t3_rlast", rlast, bi == 3);
      rready = pat[c];
      @(negedge clk);
      if (pat[c]) bi++;
    end
    rready = 1'b0;
    chk("t3_done", rvalid, 0);

    // T4 out of range
    ar_send(4'd4, BASE - 64'd8, 8'd0, INC);
    r_chk(4'd4, 64'd0, 2'b10, 1'b1);
    ar_send(4'd4, BASE + 64'd32768, 8'd0, INC);
    r_chk(4'd4, 64'd0, 2'b10, 1'b1);
    wr1(4'd2, BASE + 64'd32768, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b10);
    ar_send(4'd0, BASE, 8'd0, INC);
    r_chk(4'd0, d3[0], 2'b00, 1'b1);

    // T5 early wlast, then WRAP
    aw_send(4'd6, BASE + 64'h40, 8'd1, INC);
    w_send(64'hAAAA_0000_0000_0001, 8'hFF, 1'b1);
    w_send(64'hAAAA_0000_0000_0002, 8'hFF, 1'b1);
    b_chk(4'd6, 2'b10);
    ar_send(4'd6, BASE + 64'h40, 8'd1, INC);
    r_chk(4'd6, 64'hAAAA_0000_0000_0001, 2'b00, 1'b0);
    r_chk(4'd6, 64'hAAAA_0000_0000_0002, 2'b00, 1'b1);
    aw_send(4'd7, BASE + 64'h40, 8'd0, 2'b10);
    w_send(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    b_chk(4'd7, 2'b10);
    ar_send(4'd7, BASE + 64'h40, 8'd0, INC);
    r_chk(4'd7, 64'hAAAA_0000_0000_0001, 2'b00, 1'b1);

    // FIXED burst hits one word
    aw_send(4'd8, BASE + 64'h80, 8'd1, FIX);
    w_send(64'h0000_0000_0000_00AB, 8'hFF, 1'b0);
    w_send(64'h0000_0000_0000_00CD, 8'hFF, 1'b1);
    b_chk(4'd8, 2'b00);
    ar_send(4'd9, BASE + 64'h80, 8'd1, FIX);
    r_chk(4'd9, 64'h0000_0000_0000_00CD, 2'b00, 1'b0);
    r_chk(4'd9, 64'h0000_0000_0000_00CD, 2'b00, 1'b1);

    // T6 reset mid read burst
    aw_send(4'd1, BASE + 64'h200, 8'd7, INC);
    for (int b = 0; b < 8; b++) w_send(e8[b], 8'hFF, b == 7);
    b_chk(4'd1, 2'b00);
    ar_send(4'd3, BASE + 64'h200, 8'd7, INC);
    r_chk(4'd3, e8[0], 2'b00, 1'b0);
    r_chk(4'd3, e8[1], 2'b00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_rst", rvalid, 0);
    chk("t6_arready_rst", arready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rvalid", rvalid, 0);
    chk("t6_arready", arready, 1);
    ar_send(4'd5, BASE + 64'h218, 8'd0, INC);
    r_chk(4'd5, e8[3], 2'b00, 1'b1);

    // reset mid write burst
    aw_send(4'd2, BASE + 64'h300, 8'd3, INC);
    w_send(64'h3030_0000_0000_0000, 8'hFF, 1'b0);
    w_send(64'h3131_0000_0000_0000, 8'hFF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6w_awready", awready, 1);
    chk("t6w_wready", wready, 0);
    chk("t6w_bvalid", bvalid, 0);
    ar_send(4'd6, BASE + 64'h300, 8'd1, INC);
    r_chk(4'd6, 64'h3030_0000_0000_0000, 2'b00, 1'b0);
    r_chk(4'd6, 64'h3131_0000_0000_0000, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
